// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the VGA sync controller:
//   - 640x480@60 timing constants (pixels per line segment, lines per frame segment)
//   - derived line/frame totals and sync pulse start/end positions
//   - run/stop FSM state encoding
//   - in_range helper used for the sync pulse windows
package vga_timing_pkg;

  localparam int VGA_DIV      = 4;    // master clocks per pixel at 100 MHz

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP; // 800
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP; // 525
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;                         // 656
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;               // 751
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;                         // 490
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;               // 491

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } vga_state_e;

  // True when lo <= v <= hi (inclusive window).
  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen
// Divide-by-DIV enable generator. While iclr is low the counter runs
// 0..DIV-1 and otick is high for the one iclk cycle where it sits at DIV-1.
// iclr holds the counter at 0 so the first tick lands DIV cycles after release.
// Ports:
//   iclk      in   master clock
//   irst_n    in   asynchronous active-low reset
//   iclr      in   synchronous clear (hold counter at 0, no ticks)
//   otick     out  registered pixel enable, one iclk wide
//   otick_pre out  combinational: otick will be high in the next cycle
module pixel_tick_gen #(
  parameter int DIV = 4
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic iclr,
  output logic otick,
  output logic otick_pre
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt_r;
  logic [DW-1:0] div_cnt_nxt_s;
  logic          tick_r;

  // Next divider count: cleared, wrapping at DIV-1, or incrementing.
  always_comb begin
    div_cnt_nxt_s = div_cnt_r;
    if (iclr) begin
      div_cnt_nxt_s = '0;
    end else if (div_cnt_r == LAST) begin
      div_cnt_nxt_s = '0;
    end else begin
      div_cnt_nxt_s = div_cnt_r + DW'(1);
    end
  end

  assign otick_pre = (div_cnt_nxt_s == LAST);

  // Divider count and registered tick (tick mirrors div_cnt == DIV-1).
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      div_cnt_r <= '0;
      tick_r    <= 1'b0;
    end else begin
      div_cnt_r <= div_cnt_nxt_s;
      tick_r    <= otick_pre;
    end
  end

  assign otick = tick_r;

endmodule

// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl
// VGA timing controller running from the master clock with a pixel-rate
// enable (no derived clock). A run/stop FSM starts scanning on ien and,
// once ien drops, finishes the current frame before returning to IDLE.
// Every output is a register loaded from next-state values, so position,
// syncs and active-video always agree and the sync pins cannot glitch.
// Ports:
//   iclk          in   master clock (100 MHz)
//   irst_n        in   asynchronous active-low reset
//   ien           in   run request (level)
//   otick         out  pixel enable, one iclk wide, every DIV cycles
//   ox / oy       out  horizontal / vertical position
//   ohsync/ovsync out  active-low sync pulses
//   ovideo_on     out  position inside the active area
//   oframe_start  out  pulse with the tick at (0,0)
//   oline_end     out  pulse with the tick at the last pixel of a line
//   obusy         out  FSM in RUN or STOP
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int DIV      = VGA_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       ien,
  output logic       otick,
  output logic [9:0] ox,
  output logic [9:0] oy,
  output logic       ohsync,
  output logic       ovsync,
  output logic       ovideo_on,
  output logic       oframe_start,
  output logic       oline_end,
  output logic       obusy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Counters are 10 bits wide; geometry must fit and the divider needs >= 2.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_sync_ctrl: line or frame total exceeds 10-bit counter range");
  end
  if (DIV < 2) begin : g_div_check
    $error("vga_sync_ctrl: DIV must be at least 2");
  end

  vga_state_e state_r, state_nxt_s;
  logic [9:0] ox_r, oy_r, ox_nxt_s, oy_nxt_s;
  logic       tick_s, tick_pre_s, clr_s, frame_end_s;
  logic       hsync_r, vsync_r, video_on_r, frame_start_r, line_end_r, busy_r;

  assign clr_s = (state_r == IDLE);

  pixel_tick_gen #(.DIV(DIV)) u_tick (
    .iclk      (iclk),
    .irst_n    (irst_n),
    .iclr      (clr_s),
    .otick     (tick_s),
    .otick_pre (tick_pre_s)
  );

  assign frame_end_s = tick_s && (ox_r == H_LAST) && (oy_r == V_LAST);

  // Run/stop next state; STOP only leaves for IDLE on the last tick of a frame.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ien) state_nxt_s = RUN;
        else     state_nxt_s = IDLE;
      end
      RUN: begin
        if (!ien) state_nxt_s = STOP;
        else      state_nxt_s = RUN;
      end
      STOP: begin
        if (ien)              state_nxt_s = RUN;
        else if (frame_end_s) state_nxt_s = IDLE;
        else                  state_nxt_s = STOP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next position: forced to origin whenever we are (or become) idle.
  always_comb begin
    ox_nxt_s = ox_r;
    oy_nxt_s = oy_r;
    if (state_nxt_s == IDLE) begin
      ox_nxt_s = 10'd0;
      oy_nxt_s = 10'd0;
    end else if (tick_s) begin
      if (ox_r == H_LAST) begin
        ox_nxt_s = 10'd0;
        if (oy_r == V_LAST) oy_nxt_s = 10'd0;
        else                oy_nxt_s = oy_r + 10'd1;
      end else begin
        ox_nxt_s = ox_r + 10'd1;
      end
    end else begin
      ox_nxt_s = ox_r;
      oy_nxt_s = oy_r;
    end
  end

  // FSM state, position and all decoded outputs, loaded together.
  // Marker pulses are armed on the edge before a tick; DIV >= 2 guarantees
  // that edge never moves the counters, so ox_nxt/oy_nxt are the tick position.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_r       <= IDLE;
      ox_r          <= 10'd0;
      oy_r          <= 10'd0;
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      video_on_r    <= 1'b0;
      frame_start_r <= 1'b0;
      line_end_r    <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      ox_r          <= ox_nxt_s;
      oy_r          <= oy_nxt_s;
      hsync_r       <= ~in_range(ox_nxt_s, HS_START, HS_END);
      vsync_r       <= ~in_range(oy_nxt_s, VS_START, VS_END);
      video_on_r    <= (state_nxt_s != IDLE) && (ox_nxt_s < H_ACT) && (oy_nxt_s < V_ACT);
      frame_start_r <= tick_pre_s && (ox_nxt_s == 10'd0) && (oy_nxt_s == 10'd0);
      line_end_r    <= tick_pre_s && (ox_nxt_s == H_LAST);
      busy_r        <= (state_nxt_s != IDLE);
    end
  end

  assign otick        = tick_s;
  assign ox           = ox_r;
  assign oy           = oy_r;
  assign ohsync       = hsync_r;
  assign ovsync       = vsync_r;
  assign ovideo_on    = video_on_r;
  assign oframe_start = frame_start_r;
  assign oline_end    = line_end_r;
  assign obusy        = busy_r;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb_vga_sync_ctrl
// Two instances share clock and reset: a shrunken geometry (25x17 positions)
// exercises whole frames, stop/restart and reset; the 640x480 default
// instance checks one complete line at real timing.
module tb_vga_sync_ctrl;

  localparam int DIV = 4;
  // Small geometry: H 16/2/4/3 (total 25), V 10/2/2/3 (total 17)
  localparam int SHT   = 25;
  localparam int SVT   = 17;
  localparam int FRAME = SHT * SVT;   // 425 ticks
  localparam int HS_LO = 18, HS_HI = 21, VS_LO = 12, VS_HI = 13;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic       irst_n, ien_s, ien_d;
  logic       s_tick, s_hs, s_vs, s_von, s_fs, s_le, s_busy;
  logic [9:0] s_x, s_y;
  logic       d_tick, d_hs, d_vs, d_von, d_fs, d_le, d_busy;
  logic [9:0] d_x, d_y;

  vga_sync_ctrl #(
    .DIV(DIV), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .iclk(iclk), .irst_n(irst_n), .ien(ien_s), .otick(s_tick), .ox(s_x), .oy(s_y),
    .ohsync(s_hs), .ovsync(s_vs), .ovideo_on(s_von), .oframe_start(s_fs),
    .oline_end(s_le), .obusy(s_busy)
  );

  vga_sync_ctrl #(.DIV(DIV)) u_full (
    .iclk(iclk), .irst_n(irst_n), .ien(ien_d), .otick(d_tick), .ox(d_x), .oy(d_y),
    .ohsync(d_hs), .ovsync(d_vs), .ovideo_on(d_von), .oframe_start(d_fs),
    .oline_end(d_le), .obusy(d_busy)
  );

  typedef struct {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic von;
    logic fs;
    logic le;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int last_tick = -1;
  int px = 0, py = 0;
  int k, von_n, hs_n, hs_first, le_n, le_x, lat, waited, lastd;

  always @(posedge iclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    e.x   = x;
    e.y   = y;
    e.hs  = (x >= HS_LO && x <= HS_HI) ? 1'b0 : 1'b1;
    e.vs  = (y >= VS_LO && y <= VS_HI) ? 1'b0 : 1'b1;
    e.von = (x < 16 && y < 10) ? 1'b1 : 1'b0;
    e.fs  = (x == 0 && y == 0) ? 1'b1 : 1'b0;
    e.le  = (x == SHT - 1) ? 1'b1 : 1'b0;
    return e;
  endfunction

  // Queue the expected outputs of the next n ticks of the small instance.
  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model(px, py));
      if (px == SHT - 1) begin
        px = 0;
        py = (py == SVT - 1) ? 0 : py + 1;
      end else begin
        px++;
      end
    end
  endtask

  task automatic check_tick();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_tick", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    chk("ox", s_x, e.x);
    chk("oy", s_y, e.y);
    chk("ohsync", s_hs, e.hs);
    chk("ovsync", s_vs, e.vs);
    chk("ovideo_on", s_von, e.von);
    chk("oframe_start", s_fs, e.fs);
    chk("oline_end", s_le, e.le);
    if (last_tick >= 0) chk("tick_gap", cyc - last_tick, DIV);
    last_tick = cyc;
  endtask

  task automatic drain(input int n);
    int got = 0;
    int w = 0;
    while (got < n && w < n * DIV + 16) begin
      @(negedge iclk);
      w++;
      if (s_tick) begin
        check_tick();
        got++;
      end else begin
        chk("pulse_off_tick", {s_fs, s_le}, 2'b00);
      end
    end
    if (got < n) chk("drain_timeout", got, n);
  endtask

  // Fresh scan from (0,0): queue n ticks, raise ien, check start latency.
  task automatic begin_frame(input int n);
    int l = 0;
    exp_q.delete();
    px = 0;
    py = 0;
    last_tick = -1;
    push(n);
    @(negedge iclk);
    ien_s = 1'b1;
    do begin
      @(negedge iclk);
      l++;
    end while (!s_tick && l < 12);
    chk("first_tick_latency", l, DIV);
    chk("busy_after_start", s_busy, 1);
    if (s_tick) check_tick();
  endtask

  task automatic idle_check(input string tag, input int n);
    int ticks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      if (s_tick) ticks++;
    end
    chk(tag, ticks, 0);
    chk("idle_outputs", {s_hs, s_vs, s_von, s_fs, s_le, s_busy, s_x, s_y},
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    irst_n = 1'b0;
    ien_s  = 1'b0;
    ien_d  = 1'b0;
    repeat (3) @(negedge iclk);
    irst_n = 1'b1;

    // Idle after reset with ien low
    for (int i = 0; i < 100; i++) begin
      @(negedge iclk);
      chk("reset_idle_small", {s_tick, s_hs, s_vs, s_von, s_fs, s_le, s_busy, s_x, s_y},
          {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});
      chk("reset_idle_full", {d_tick, d_hs, d_vs, d_von, d_fs, d_le, d_busy, d_x, d_y},
          {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});
    end

    // Two full frames
    begin_frame(2 * FRAME);
    drain(2 * FRAME - 1);

    // Drop ien at (10,5): frame completes, then IDLE
    push(136);
    drain(136);
    ien_s = 1'b0;
    push(FRAME - 136);
    drain(10);
    chk("stop_busy", s_busy, 1);
    drain(FRAME - 146);
    idle_check("no_tick_after_stop", 20);

    // Re-assert ien while in STOP: tick spacing must stay continuous
    begin_frame(54);
    drain(53);
    ien_s = 1'b0;
    push(20);
    drain(20);
    ien_s = 1'b1;
    push(30);
    drain(30);

    // ien drops on the final tick of a frame in RUN: one more full frame
    push(FRAME - 1 - 103);
    drain(FRAME - 1 - 103);
    ien_s = 1'b0;
    push(FRAME);
    drain(FRAME);
    idle_check("no_tick_after_extra_frame", 20);

    // Asynchronous reset in the middle of the tick at (12,8)
    begin_frame(213);
    drain(212);
    #2;
    irst_n = 1'b0;
    ien_s  = 1'b0;
    #1;
    chk("async_reset_outputs", {s_tick, s_hs, s_vs, s_von, s_fs, s_le, s_busy, s_x, s_y},
        {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});
    @(negedge iclk);
    irst_n = 1'b1;
    idle_check("no_tick_after_reset", 20);

    // Full 640x480 geometry: one complete line
    @(negedge iclk);
    ien_d = 1'b1;
    lat = 0;
    do begin
      @(negedge iclk);
      lat++;
    end while (!d_tick && lat < 12);
    chk("full_first_tick_latency", lat, DIV);
    chk("full_frame_start", d_fs, 1);
    k = 0; von_n = 0; hs_n = 0; hs_first = -1; le_n = 0; le_x = -1; waited = 0; lastd = -1;
    while (1) begin
      if (d_tick) begin
        if (k < 800) begin
          chk("full_ox", d_x, k);
          chk("full_oy", d_y, 0);
          if (d_von) von_n++;
          if (!d_hs) begin
            hs_n++;
            if (hs_first < 0) hs_first = k;
          end
          if (d_le) begin
            le_n++;
            le_x = k;
          end
        end else begin
          chk("full_wrap_ox", d_x, 0);
          chk("full_wrap_oy", d_y, 1);
        end
        if (lastd >= 0) chk("full_tick_gap", cyc - lastd, DIV);
        lastd = cyc;
        k++;
      end
      if (k > 800 || waited >= 4000) break;
      @(negedge iclk);
      waited++;
    end
    chk("full_line_ticks", k, 801);
    chk("full_video_on_ticks", von_n, 640);
    chk("full_hsync_low_ticks", hs_n, 96);
    chk("full_hsync_first_x", hs_first, 656);
    chk("full_line_end_count", le_n, 1);
    chk("full_line_end_x", le_x, 799);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_ctrl.md
# vga_sync_ctrl

Controller that sequences the VGA pixel datapath from the 100 MHz master clock: it generates a single-domain pixel-rate enable, with no derived clock, and drives horizontal/vertical counters, sync pulses, the active-video flag and frame/line markers. It sits between the master clock input and the mouse/pixel renderers, which consume `otick`, `ox`, `oy` and `ovideo_on`. A run/stop FSM starts scanning on request and always completes the current frame before stopping, so the monitor never sees a truncated frame.

## Interface
- DIV, 4, master clocks per pixel (≥2); 100 MHz/4 = 25 MHz pixel rate
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48, horizontal pixels (total 800)
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33, vertical lines (total 525)

- iclk  in  1  master clock, 100 MHz
- irst_n  in  1  reset, asynchronous, active-low
- ien  in  1  run request (level)
- otick  out  1  pixel enable, one iclk wide, every DIV cycles while scanning
- ox  out  10  horizontal count (0..799)
- oy  out  10  vertical count (0..524)
- ohsync  out  1  horizontal sync, active-low
- ovsync  out  1  vertical sync, active-low
- ovideo_on  out  1  high when ox<H_ACTIVE and oy<V_ACTIVE
- oframe_start  out  1  one-iclk pulse coincident with otick at position (0,0)
- oline_end  out  1  one-iclk pulse coincident with otick at ox=799
- obusy  out  1  high in RUN or STOP

## Operation
- Reset values: state IDLE; div_cnt 0; ox/oy 0; ohsync 1; ovsync 1; ovideo_on 0; otick, oframe_start, oline_end and obusy 0.
- FSM states:
  - IDLE: counters held at 0; syncs high; no ticks. ien=1 → RUN.
  - RUN: divider and counters run. ien=0 → STOP.
  - STOP: keeps scanning. ien=1 → RUN with no discontinuity. Tick at (799,524) → IDLE, counters forced to 0.
- Divider: div_cnt counts 0..DIV-1 in RUN/STOP. otick=1 when div_cnt==DIV-1.
- On each tick:
  - ox increments; at 799 it wraps to 0 and oy increments.
  - oy wraps 524→0.
- ohsync=0 for ox in [656,751]. ovsync=0 for oy in [490,491].
- All outputs are registered and updated on the same edge as the counters from next-state values. ox, oy, ohsync, ovsync and ovideo_on are therefore always mutually consistent, and sync pins are glitch-free.
- Width rule: counters are 10 bits; totals must be ≤1024 (elaboration check).

## Timing
- ien sampled high at edge E0 in IDLE → state RUN after E0.
- First otick is high in the cycle after edge E0+DIV-1; oframe_start is high in that same cycle, with ox=oy=0.
- Counters advance at the edge that ends a tick cycle. Tick spacing is exactly DIV iclk cycles.
- ien deasserted mid-frame: scanning continues to the end of the frame. The final tick at (799,524) is followed by IDLE on the next edge; no further ticks.
- Simultaneous ien=0 and the final tick while in RUN: go to STOP. The frame wraps and one additional full frame completes.
- Asynchronous reset mid-frame: all outputs go to their reset values immediately; restart requires ien.

## Structure
- Package vga_timing_pkg holds:
  - 640x480@60 timing constants
  - derived totals and sync start/end values
  - FSM state enum (IDLE, RUN, STOP)
- Sub-module pixel_tick_gen: DIV-cycle enable generator with a clear input. vga_sync_ctrl instantiates it once and clears it in IDLE.

## Test plan
- Reset: irst_n=0 then 1 with ien=0 → ohsync=ovsync=1, ox=oy=0, otick=0, obusy=0 for 100 cycles.
- Start with DIV=4: raise ien → first otick and oframe_start 4 cycles later; otick period exactly 4; ox increments once per tick.
- Horizontal timing: one line → ovideo_on high for 640 ticks. ohsync low for exactly 96 ticks starting at ox=656. oline_end pulses at ox=799, then ox=0 and oy=1.
- Frame wrap: run 2 frames → ovsync low for 2 lines (oy 490–491). oframe_start pulses once per 800×525 ticks.
- Stop/restart:
  - drop ien at (100,200) → frame completes, IDLE after the (799,524) tick, obusy=0;
  - re-assert ien during STOP → no gap in tick sequence.
- Asynchronous reset at (300,300) mid-tick → outputs return to reset values before the next iclk edge.
